// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding and
// fetch-related constants.
package fetch_pkg;

  // REQ: request on the bus; WAIT: granted, awaiting response;
  // HOLD: response buffered while decode is stalled;
  // DROP: a redirect orphaned a pending response that must be swallowed.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Redirect targets are forced to word alignment.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch sequencer
// (master) and the instruction memory or cache (slave).
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, keeps at most one instruction-memory request
// outstanding, buffers a returned instruction while decode is stalled, and
// drives the pc/instr/stall/flush inputs of the IF/ID register.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                hazard_stall,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  fetch_ctrl_if.master        imem,
  output logic [31:0]         if_pc,
  output logic [31:0]         if_instr,
  output logic                if_stall,
  output logic                if_flush
);
  import fetch_pkg::*;

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [31:0]  buf_q;
  logic [31:0]  buf_d;

  logic         avail;
  logic         deliver;
  logic [31:0]  instr_src;

  // An instruction is available from the live response in WAIT or from the buffer in HOLD
  always_comb begin
    avail     = ((state_q == ST_WAIT) && imem.imem_rvalid) || (state_q == ST_HOLD);
    instr_src = (state_q == ST_HOLD) ? buf_q : imem.imem_rdata;
    deliver   = avail && !hazard_stall && !redirect_valid;
  end

  // Next-state, PC and buffer update; a redirect overrides everything else
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;

    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
    end else if (deliver) begin
      pc_d = pc_q + PC_STEP;
    end

    case (state_q)
      ST_REQ: begin
        // A grant coinciding with a redirect still produces a response, which must be dropped
        if (imem.imem_gnt) state_d = redirect_valid ? ST_DROP : ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          state_d = imem.imem_rvalid ? ST_REQ : ST_DROP;
        end else if (imem.imem_rvalid) begin
          if (hazard_stall) begin
            buf_d   = imem.imem_rdata;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_HOLD: begin
        if (redirect_valid || !hazard_stall) state_d = ST_REQ;
      end
      ST_DROP: begin
        if (imem.imem_rvalid) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase
  end

  // FSM, PC and instruction buffer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      buf_q   <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  // Outputs; reset gating keeps the bus idle and IF/ID flushing while reset_n is low
  always_comb begin
    imem.imem_req  = reset_n && (state_q == ST_REQ);
    imem.imem_addr = pc_q;
    if_pc          = pc_q;
    if_instr       = avail ? instr_src : NOP_INSTR;
    if_stall       = reset_n && hazard_stall && !redirect_valid;
    if_flush       = !reset_n || redirect_valid || (!hazard_stall && !avail);
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch sequencer that owns the program counter and the instruction-memory handshake, and drives the pc/instruction/stall/flush inputs of the IF/ID pipeline register. It allows one outstanding memory request and buffers a returned instruction while decode is stalled. It discards in-flight responses on a branch/jump redirect from EX. It sits between the PC logic, instruction memory/cache and the IF/ID register.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
NOP_INSTR, 32'h0000_0013, instruction value presented on if_instr when no valid instruction is available

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
hazard_stall  in  1  decode hazard; IF/ID must hold
redirect_valid  in  1  taken branch/jump from EX
redirect_pc  in  32  redirect target
imem_req  out  1  request valid
imem_addr  out  32  request address (= pc)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid, at least 1 cycle after gnt
imem_rdata  in  32  response instruction
if_pc  out  32  to IF/ID pc_in
if_instr  out  32  to IF/ID instr_in
if_stall  out  1  to IF/ID stall
if_flush  out  1  to IF/ID flush (inserts NOP)

Behaviour:
- Async reset (reset_n=0): state=REQ, pc=RESET_PC, buffer=NOP_INSTR. Outputs during reset: imem_req=0, imem_addr=RESET_PC, if_pc=RESET_PC, if_instr=NOP_INSTR, if_stall=0, if_flush=1.
- The first request is issued in the first cycle after reset_n deasserts. Reset mid-transaction abandons the request; any late rvalid is ignored while in REQ.
- States:
  - REQ: imem_req=1. gnt -> WAIT.
  - WAIT: awaiting rvalid. imem_req=0.
  - HOLD: instruction buffered, decode stalled.
  - DROP: a redirect arrived while a response was pending; the next rvalid is discarded.
- Internal signal avail = (WAIT & imem_rvalid) | HOLD. Instruction source: imem_rdata in WAIT, buffer in HOLD.
- Output equations:
  - if_flush = redirect_valid | (!hazard_stall & !avail)
  - if_stall = hazard_stall & !redirect_valid
  - if_pc = pc
  - if_instr = avail ? instruction source : NOP_INSTR
  - The flush-over-stall priority of IF/ID is thereby never hit unintentionally.
- Delivery (avail & !hazard_stall & !redirect_valid): pc <= pc+4 (mod 2^32, wraps), next state REQ. In the same cycle IF/ID captures pc and the instruction.
- WAIT & rvalid & hazard_stall & !redirect: buffer <= imem_rdata, -> HOLD. HOLD remains until hazard_stall=0, then delivers.
- Redirect (highest priority, any state), pc <= {redirect_pc[31:2],2'b00}:
  - In REQ: the current request is withdrawn. -> REQ with the new address next cycle, even if gnt is high the same cycle; in that case -> DROP.
  - In WAIT without rvalid: -> DROP.
  - In WAIT with rvalid, or in HOLD: the data is discarded. -> REQ.
  - In DROP: with rvalid -> REQ; without rvalid, stay in DROP.
- DROP: rvalid -> REQ (data discarded). avail=0 in DROP.
- Latency: fixed single-cycle memory (gnt in REQ, rvalid next cycle) gives 1 instruction per 2 cycles. The redirect penalty is at least 2 bubbles.
- hazard_stall and redirect in the same cycle: redirect wins (flush=1, stall=0).

Decomposition:
- Shared package fetch_pkg: state enum (REQ, WAIT, HOLD, DROP), NOP_INSTR constant, PC_STEP=4.
- No sub-module; a single FSM plus pc/buffer registers.

Test Plan:
- Reset release, 1-cycle memory, instructions at 0x0, 0x4, 0x8 -> imem_addr 0x0, 0x4, 0x8 in successive REQ cycles. Each instruction appears on if_instr with if_flush=0 on its rvalid cycle. if_flush=1 in the intervening cycles.
- rvalid for 0x4 arrives with hazard_stall=1 for 3 cycles -> HOLD. if_stall=1, if_flush=0 for 3 cycles. Delivered with pc=0x4 when the stall drops. The next request address is 0x8.
- Redirect to 0x100 in WAIT with rvalid delayed 2 cycles -> DROP. The late rdata never appears with if_flush=0. The next request address is 0x100.
- Redirect to 0x203 coincident with rvalid and hazard_stall=1 -> if_flush=1, if_stall=0, data dropped. Next imem_addr=0x200.
- reset_n asserted in WAIT -> outputs immediately take their reset values. After release, imem_addr=RESET_PC and a stale rvalid is ignored.
- pc=0xFFFF_FFFC delivered -> next imem_addr=0x0000_0000.
